// File: rtl/tag_remap_scoreboard_pkg.sv
// Shared defaults for the tag remap scoreboard and its slot search helper.
package tag_remap_scoreboard_pkg;

    localparam int DEF_TAG_W = 8;
    localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/tag_remap_scoreboard_tag_free_finder.sv
// Round-robin free-slot search: rotate the free vector by ptr, priority-encode, undo the rotation.
module tag_free_finder
    import tag_remap_scoreboard_pkg::*;
#(
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int LOCAL_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]   busy_i,
    input  logic [LOCAL_W-1:0] ptr_i,
    output logic               found_o,
    output logic [LOCAL_W-1:0] index_o
);

    logic [DEPTH-1:0]   rot_free;
    logic [LOCAL_W-1:0] src_idx [DEPTH];
    logic [LOCAL_W-1:0] offset;
    logic               hit;

    // DEPTH is a power of two, so the LOCAL_W-bit sum wraps modulo DEPTH for free.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rot
            assign src_idx[gi]  = LOCAL_W'(gi) + ptr_i;
            assign rot_free[gi] = ~busy_i[src_idx[gi]];
        end
    endgenerate

    always_comb begin
        offset = '0;
        hit    = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (rot_free[j]) begin
                offset = LOCAL_W'(j);
                hit    = 1'b1;
            end
        end
    end

    assign found_o = hit;
    assign index_o = hit ? (offset + ptr_i) : '0;

endmodule

// File: rtl/tag_remap_scoreboard.sv
// Slot allocator with tag remap table: wide external tags in, compact local IDs out, tags back on release.
module tag_remap_scoreboard
    import tag_remap_scoreboard_pkg::*;
#(
    parameter  int TAG_W   = DEF_TAG_W,
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int LOCAL_W = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_alloc_valid,
    input  logic [TAG_W-1:0]   i_alloc_tag,
    output logic               o_alloc_ready,
    output logic [LOCAL_W-1:0] o_alloc_local,
    output logic               o_alloc_dup,
    input  logic               i_free_valid,
    input  logic [LOCAL_W-1:0] i_free_local,
    output logic [TAG_W-1:0]   o_free_tag,
    output logic               o_free_err,
    output logic [LOCAL_W:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [LOCAL_W-1:0] ptr_q, ptr_d;
    logic [LOCAL_W:0]   count_q, count_d;
    logic [TAG_W-1:0]   tag_tbl_q [DEPTH];

    logic               found;
    logic [LOCAL_W-1:0] grant_idx;
    logic               accept;
    logic               legal_free;
    logic [DEPTH-1:0]   dup_hit;

    tag_free_finder #(.DEPTH(DEPTH)) u_finder (
        .busy_i  (busy_q),
        .ptr_i   (ptr_q),
        .found_o (found),
        .index_o (grant_idx)
    );

    assign accept     = i_alloc_valid & found;
    assign legal_free = i_free_valid & busy_q[i_free_local];

    // A granted slot is idle and a legally freed slot is busy, so set and clear never collide.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign dup_hit[gi] = busy_q[gi] & (tag_tbl_q[gi] == i_alloc_tag);
            assign busy_d[gi]  = (accept && (grant_idx == LOCAL_W'(gi)))
                               | (busy_q[gi] & ~(legal_free && (i_free_local == LOCAL_W'(gi))));
        end
    endgenerate

    assign ptr_d   = accept ? (grant_idx + LOCAL_W'(1)) : ptr_q;
    assign count_d = count_q + {{LOCAL_W{1'b0}}, accept} - {{LOCAL_W{1'b0}}, legal_free};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Table contents are left stale across reset and release; busy qualifies every read.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            tag_tbl_q[grant_idx] <= i_alloc_tag;
        end
    end

    assign o_alloc_ready = found;
    assign o_alloc_local = grant_idx;
    assign o_alloc_dup   = i_alloc_valid & (|dup_hit);
    assign o_free_tag    = tag_tbl_q[i_free_local];
    assign o_free_err    = i_free_valid & ~busy_q[i_free_local];
    assign o_count       = count_q;
    assign o_full        = (count_q == (LOCAL_W + 1)'(DEPTH));
    assign o_empty       = (count_q == '0);

endmodule

// File: tb/tb_tag_remap_scoreboard.sv
// Directed bench for tag_remap_scoreboard at TAG_W=8, DEPTH=16.
module tb_tag_remap_scoreboard;

    localparam int TAG_W   = 8;
    localparam int DEPTH   = 16;
    localparam int LOCAL_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc_valid;
    logic [TAG_W-1:0]   alloc_tag;
    logic               alloc_ready;
    logic [LOCAL_W-1:0] alloc_local;
    logic               alloc_dup;
    logic               free_valid;
    logic [LOCAL_W-1:0] free_local;
    logic [TAG_W-1:0]   free_tag;
    logic               free_err;
    logic [LOCAL_W:0]   count;
    logic               full;
    logic               empty;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    tag_remap_scoreboard #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alloc_valid (alloc_valid),
        .i_alloc_tag   (alloc_tag),
        .o_alloc_ready (alloc_ready),
        .o_alloc_local (alloc_local),
        .o_alloc_dup   (alloc_dup),
        .i_free_valid  (free_valid),
        .i_free_local  (free_local),
        .o_free_tag    (free_tag),
        .o_free_err    (free_err),
        .o_count       (count),
        .o_full        (full),
        .o_empty       (empty)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_tag   = '0;
        free_valid  = 1'b0;
        free_local  = '0;

        // Outputs while reset is held
        #2;
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_local", 32'(alloc_local), 0);
        chk("rst_dup",   32'(alloc_dup),   0);
        chk("rst_empty", 32'(empty),       1);
        chk("rst_full",  32'(full),        0);
        chk("rst_count", 32'(count),       0);
        free_valid = 1'b1;
        free_local = 4'd9;
        #1 chk("rst_free_err", 32'(free_err), 1);
        free_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fill and full
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_tag   = 8'(16 + i);
            #1;
            chk("fill_grant", 32'(alloc_local), 32'(i));
            chk("fill_ready", 32'(alloc_ready), 1);
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        chk("full_flag",  32'(full),        1);
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_count", 32'(count),       16);
        alloc_valid = 1'b1;
        alloc_tag   = 8'h99;
        #1;
        chk("stall_ready", 32'(alloc_ready), 0);
        chk("stall_local", 32'(alloc_local), 0);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("stall_count", 32'(count), 16);
        chk("stall_full",  32'(full),  1);

        // Remap readback
        free_valid = 1'b1;
        free_local = 4'd5;
        #1;
        chk("free5_tag", 32'(free_tag), 32'h15);
        chk("free5_err", 32'(free_err), 0);
        tick();
        free_valid = 1'b0;
        #1;
        chk("free5_count", 32'(count),       15);
        chk("free5_ready", 32'(alloc_ready), 1);
        alloc_valid = 1'b1;
        alloc_tag   = 8'h55;
        #1 chk("regrant5", 32'(alloc_local), 5);
        tick();
        alloc_valid = 1'b0;
        #1 chk("regrant5_count", 32'(count), 16);

        // Simultaneous free and alloc while full
        free_valid  = 1'b1;
        free_local  = 4'd3;
        alloc_valid = 1'b1;
        alloc_tag   = 8'h33;
        #1;
        chk("sim_ready", 32'(alloc_ready), 0);
        chk("sim_tag",   32'(free_tag),    32'h13);
        tick();
        free_valid = 1'b0;
        #1;
        chk("sim_count", 32'(count),       15);
        chk("sim_grant", 32'(alloc_local), 3);
        tick();
        alloc_valid = 1'b0;
        #1 chk("sim_count2", 32'(count), 16);

        // Round-robin, illegal free, duplicate tag
        pulse_reset();
        chk("rr_reset_count", 32'(count), 0);
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_tag   = 8'h20;
        #1 chk("rr_grant0", 32'(alloc_local), 0);
        tick();
        alloc_tag = 8'h21;
        #1 chk("rr_grant1", 32'(alloc_local), 1);
        tick();
        alloc_valid = 1'b0;
        free_valid  = 1'b1;
        free_local  = 4'd0;
        #1;
        chk("rr_free0_tag", 32'(free_tag), 32'h20);
        chk("rr_free0_err", 32'(free_err), 0);
        tick();
        free_local = 4'd7;
        #1 chk("err_free7", 32'(free_err), 1);
        tick();
        free_valid = 1'b0;
        #1 chk("err_count", 32'(count), 1);
        alloc_valid = 1'b1;
        alloc_tag   = 8'h42;
        #1;
        chk("rr_grant2", 32'(alloc_local), 2);
        chk("rr_nodup",  32'(alloc_dup),   0);
        tick();
        #1;
        chk("dup_flag",  32'(alloc_dup),   1);
        chk("dup_grant", 32'(alloc_local), 3);
        tick();
        #1 chk("dup_count", 32'(count), 3);
        for (int s = 4; s < 16; s++) begin
            alloc_tag = 8'(8'h40 + s);
            #1 chk("rr_grant", 32'(alloc_local), 32'(s));
            tick();
        end
        alloc_tag = 8'h50;
        #1;
        chk("rr_wrap_grant", 32'(alloc_local), 0);
        chk("rr_wrap_dup",   32'(alloc_dup),   0);
        tick();
        alloc_valid = 1'b0;
        #1 chk("rr_wrap_count", 32'(count), 16);

        // Concurrent accept and free of a different slot, then async reset mid-traffic
        pulse_reset();
        @(negedge clk);
        alloc_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            alloc_tag = 8'(8'h60 + i);
            #1;
            tick();
        end
        chk("mid_count9", 32'(count), 9);
        free_valid = 1'b1;
        free_local = 4'd0;
        alloc_tag  = 8'h69;
        #1 chk("both_grant", 32'(alloc_local), 9);
        tick();
        free_valid  = 1'b0;
        alloc_valid = 1'b0;
        #1 chk("both_count", 32'(count), 9);
        #1 rst = 1'b1;
        #1;
        chk("async_count", 32'(count),       0);
        chk("async_empty", 32'(empty),       1);
        chk("async_ready", 32'(alloc_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_tag   = 8'h77;
        #1 chk("post_rst_grant", 32'(alloc_local), 0);
        tick();
        alloc_valid = 1'b0;
        #1 chk("post_rst_count", 32'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
